// File: rtl/rv32_pkg.sv
// Shared RV32 types used by the core front end, memory wrappers and their arbiters.
package rv32_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned IMEM_ADDR_W = 10;

  typedef logic [XLEN-1:0]        rv32_data_t;
  typedef logic [IMEM_ADDR_W-1:0] rv32_dmem_addr_t;

  // Which requester the read data returning next cycle belongs to.
  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_FETCH = 2'd1,
    OWNER_HOST  = 2'd2
  } rv32_imem_owner_t;

endpackage

// File: rtl/rv32_imem_arbiter.sv
// Shares the instruction BRAM between core fetch (read priority) and a host
// programming port, with a starvation counter that forces host progress.
module rv32_imem_arbiter
  import rv32_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            fetch_req,
  input  rv32_dmem_addr_t fetch_addr,
  output logic            fetch_gnt,
  output logic            fetch_rvalid,
  output rv32_data_t      fetch_data,
  input  logic            host_valid,
  input  logic            host_we,
  input  rv32_dmem_addr_t host_addr,
  input  rv32_data_t      host_wdata,
  output logic            host_ready,
  output logic            host_rvalid,
  output rv32_data_t      host_rdata,
  output rv32_dmem_addr_t mem_rdaddress,
  output rv32_dmem_addr_t mem_wraddress,
  output rv32_data_t      mem_data,
  output logic            mem_wren,
  input  rv32_data_t      mem_q
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  rv32_imem_owner_t owner;
  logic [3:0]       starve_cnt;
  logic             force_host;
  logic             collision;
  logic             host_rd_acc;

  // NOTE: every signal gets a default at the top of the block so no path
  // through the if/else can leave it unassigned and infer a latch.
  always_comb begin
    force_host    = host_valid && (starve_cnt == LIMIT);
    collision     = fetch_req && (fetch_addr == host_addr);
    host_ready    = 1'b0;
    fetch_gnt     = 1'b0;
    if (host_we) begin
      // Writes only contend with a fetch of the very same word.
      host_ready = !collision || force_host;
      fetch_gnt  = fetch_req && !(force_host && collision);
    end else begin
      host_ready = !fetch_req || force_host;
      fetch_gnt  = fetch_req && !(host_valid && force_host);
    end
    host_rd_acc   = host_valid && !host_we && host_ready;
    mem_rdaddress = host_rd_acc ? host_addr : fetch_addr;
  end

  assign mem_wren      = host_valid && host_we && host_ready;
  assign mem_wraddress = host_addr;
  assign mem_data      = host_wdata;

  assign fetch_rvalid  = (owner == OWNER_FETCH);
  assign host_rvalid   = (owner == OWNER_HOST);
  assign fetch_data    = mem_q;
  assign host_rdata    = mem_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner      <= OWNER_NONE;
      starve_cnt <= '0;
    end else begin
      if (host_rd_acc)    owner <= OWNER_HOST;
      else if (fetch_gnt) owner <= OWNER_FETCH;
      else                owner <= OWNER_NONE;

      if (!host_valid || host_ready) starve_cnt <= '0;
      else if (starve_cnt != LIMIT)  starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_rv32_imem_arbiter.sv
// Directed bench for rv32_imem_arbiter with a per-cycle behavioural reference model.
module tb_rv32_imem_arbiter;
  import rv32_pkg::*;

  localparam int LIMIT = 4;
  localparam int DEPTH = 1 << IMEM_ADDR_W;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            fetch_req = 1'b0;
  rv32_dmem_addr_t fetch_addr = '0;
  logic            fetch_gnt, fetch_rvalid;
  rv32_data_t      fetch_data;
  logic            host_valid = 1'b0;
  logic            host_we = 1'b0;
  rv32_dmem_addr_t host_addr = '0;
  rv32_data_t      host_wdata = '0;
  logic            host_ready, host_rvalid;
  rv32_data_t      host_rdata;
  rv32_dmem_addr_t mem_rdaddress, mem_wraddress;
  rv32_data_t      mem_data;
  logic            mem_wren;
  rv32_data_t      mem_q;

  rv32_imem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_data(fetch_data),
    .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ready(host_ready), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .mem_rdaddress(mem_rdaddress),
    .mem_wraddress(mem_wraddress), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q)
  );

  initial forever #5 clock = ~clock;

  // Instruction BRAM stand-in: registered read, one cycle latency.
  rv32_data_t tb_mem [DEPTH];
  always @(posedge clock) begin
    if (mem_wren) tb_mem[mem_wraddress] <= mem_data;
    mem_q <= tb_mem[mem_rdaddress];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: shadow memory, consecutive-denial count and the
  // response expected in the following cycle.
  rv32_data_t ref_mem [DEPTH];
  int         denied = 0;
  bit         exp_frv = 0, exp_hrv = 0;
  rv32_data_t exp_fdata = '0, exp_hdata = '0;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i]  = 32'hA000_0000 + i;
      ref_mem[i] = 32'hA000_0000 + i;
    end
  end

  initial forever begin
    bit forced, coll, e_ready, e_gnt, acc, e_wren;
    rv32_dmem_addr_t e_rdaddr;
    @(negedge clock);
    if (reset) begin
      exp_frv = 0;
      exp_hrv = 0;
      denied  = 0;
    end
    check("fetch_rvalid", fetch_rvalid, exp_frv);
    check("host_rvalid", host_rvalid, exp_hrv);
    if (exp_frv) check("fetch_data", fetch_data, exp_fdata);
    if (exp_hrv) check("host_rdata", host_rdata, exp_hdata);

    forced = host_valid && (denied >= LIMIT);
    if (host_we) begin
      coll    = fetch_req && (fetch_addr == host_addr);
      e_ready = !coll || forced;
      e_gnt   = fetch_req && !(forced && coll);
    end else begin
      e_ready = !fetch_req || forced;
      e_gnt   = fetch_req && !(host_valid && forced);
    end
    acc      = host_valid && e_ready;
    e_wren   = acc && host_we;
    e_rdaddr = (acc && !host_we) ? host_addr : fetch_addr;
    check("fetch_gnt", fetch_gnt, e_gnt);
    check("host_ready", host_ready, e_ready);
    check("mem_wren", mem_wren, e_wren);
    check("mem_rdaddress", mem_rdaddress, e_rdaddr);
    if (e_wren) begin
      check("mem_wraddress", mem_wraddress, host_addr);
      check("mem_data", mem_data, host_wdata);
    end

    if (!reset) begin
      exp_hrv = acc && !host_we;
      if (exp_hrv) exp_hdata = ref_mem[host_addr];
      exp_frv = e_gnt;
      if (exp_frv) exp_fdata = ref_mem[fetch_addr];
      if (e_wren) ref_mem[host_addr] = host_wdata;
      denied = (!host_valid || acc) ? 0 : denied + 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Counts cycles (starting with the current one) until the host is accepted.
  task automatic wait_accept(output int cyc);
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (host_ready) begin
        cyc = k;
        break;
      end
      tick();
    end
  endtask

  int acc_cycle;

  initial begin
    tick();
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("reset_fetch_rvalid", fetch_rvalid, 1'b0);
    check("reset_host_rvalid", host_rvalid, 1'b0);

    // Fetch-only stream of words 0,1,2.
    tick();
    for (int a = 0; a < 3; a++) begin
      fetch_req  = 1'b1;
      fetch_addr = rv32_dmem_addr_t'(a);
      @(negedge clock);
      check("stream_gnt", fetch_gnt, 1'b1);
      tick();
    end
    fetch_req = 1'b0;
    @(negedge clock);
    check("stream_last_rvalid", fetch_rvalid, 1'b1);
    check("stream_last_data", fetch_data, 32'hA000_0002);
    tick();

    // Host write then read-back of word 0x10.
    host_valid = 1'b1;
    host_we    = 1'b1;
    host_addr  = 10'h010;
    host_wdata = 32'hDEAD_BEEF;
    @(negedge clock);
    check("hw_wren", mem_wren, 1'b1);
    tick();
    host_we = 1'b0;
    @(negedge clock);
    check("hr_ready", host_ready, 1'b1);
    check("hr_rdaddress", mem_rdaddress, 10'h010);
    tick();
    host_valid = 1'b0;
    @(negedge clock);
    check("hr_rvalid", host_rvalid, 1'b1);
    check("hr_rdata", host_rdata, 32'hDEAD_BEEF);
    tick();

    // Host read starved by a continuous fetch stream.
    fetch_req  = 1'b1;
    fetch_addr = 10'h005;
    host_valid = 1'b1;
    host_we    = 1'b0;
    host_addr  = 10'h010;
    wait_accept(acc_cycle);
    check("starve_accept_cycle", acc_cycle, 5);
    check("forced_fetch_gnt", fetch_gnt, 1'b0);
    tick();
    host_valid = 1'b0;
    @(negedge clock);
    check("forced_host_rvalid", host_rvalid, 1'b1);
    check("forced_fetch_rvalid", fetch_rvalid, 1'b0);
    check("forced_host_rdata", host_rdata, 32'hDEAD_BEEF);
    tick();

    // Host write colliding with a fetch of the same word, then a different one.
    fetch_addr = 10'h020;
    host_valid = 1'b1;
    host_we    = 1'b1;
    host_addr  = 10'h020;
    host_wdata = 32'h1234_5678;
    @(negedge clock);
    check("coll_host_ready", host_ready, 1'b0);
    check("coll_fetch_gnt", fetch_gnt, 1'b1);
    check("coll_wren", mem_wren, 1'b0);
    tick();
    fetch_addr = 10'h021;
    @(negedge clock);
    check("split_host_ready", host_ready, 1'b1);
    check("split_fetch_gnt", fetch_gnt, 1'b1);
    check("split_wren", mem_wren, 1'b1);
    tick();
    host_valid = 1'b0;
    fetch_addr = 10'h020;
    @(negedge clock);
    check("split_fetch_data", fetch_data, 32'hA000_0021);
    tick();
    fetch_req = 1'b0;
    @(negedge clock);
    check("written_word_fetch", fetch_data, 32'h1234_5678);
    tick();

    // Reset while a fetch response is in flight and the host is partly starved.
    fetch_req  = 1'b1;
    fetch_addr = 10'h003;
    host_valid = 1'b1;
    host_we    = 1'b0;
    host_addr  = 10'h010;
    tick();
    tick();
    reset = 1'b1;
    @(negedge clock);
    check("rst_drops_fetch_rvalid", fetch_rvalid, 1'b0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_fetch_gnt", fetch_gnt, 1'b1);
    check("post_rst_rvalid", fetch_rvalid, 1'b0);
    check("post_rst_host_ready", host_ready, 1'b0);
    tick();
    wait_accept(acc_cycle);
    check("post_rst_accept_cycle", acc_cycle + 1, 5);
    tick();
    fetch_req  = 1'b0;
    host_valid = 1'b0;
    @(negedge clock);
    check("post_rst_host_rvalid", host_rvalid, 1'b1);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
